// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the hazard/forwarding controller: widths, the
// scoreboard entry layout and the saturating counter helper.
package hazard_forward_unit_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 16;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // One in-flight producer tracked by the scoreboard.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  regwrite;
        logic                  memread;
    } sb_entry_t;

    localparam sb_entry_t SB_INVALID = '{dest: ZERO_REG, regwrite: 1'b0, memread: 1'b0};

    // Increment by one when enabled, sticking at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value, input logic en);
        logic [CNT_W-1:0] result;
        result = value;
        if (en && (value != CNT_MAX)) begin
            result = value + CNT_ONE;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Bus between the ID stage / pipeline registers and the hazard controller.
// The pipeline (master) presents the ID instruction and branch outcome; the
// controller (slave) returns stall/flush controls, operand selects and counters.
interface hazard_forward_unit_if;

    logic                                          pipe_freeze;
    logic [hazard_forward_unit_pkg::REG_ADDR_W-1:0] id_rs;
    logic [hazard_forward_unit_pkg::REG_ADDR_W-1:0] id_rt;
    logic                                          id_uses_rs;
    logic                                          id_uses_rt;
    logic [hazard_forward_unit_pkg::REG_ADDR_W-1:0] id_dest;
    logic                                          id_regwrite;
    logic                                          id_memread;
    logic                                          ex_branch_taken;

    logic                                          pc_hold;
    logic                                          ifid_hold;
    logic                                          ifid_flush;
    logic                                          idex_bubble;
    logic                                          fwd_a_wb_sel;
    logic                                          fwd_a_mem_sel;
    logic                                          fwd_b_wb_sel;
    logic                                          fwd_b_mem_sel;
    logic [hazard_forward_unit_pkg::CNT_W-1:0]      stall_count;
    logic [hazard_forward_unit_pkg::CNT_W-1:0]      flush_count;

    modport master (
        output pipe_freeze, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
               id_regwrite, id_memread, ex_branch_taken,
        input  pc_hold, ifid_hold, ifid_flush, idex_bubble,
               fwd_a_wb_sel, fwd_a_mem_sel, fwd_b_wb_sel, fwd_b_mem_sel,
               stall_count, flush_count
    );

    modport slave (
        input  pipe_freeze, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
               id_regwrite, id_memread, ex_branch_taken,
        output pc_hold, ifid_hold, ifid_flush, idex_bubble,
               fwd_a_wb_sel, fwd_a_mem_sel, fwd_b_wb_sel, fwd_b_mem_sel,
               stall_count, flush_count
    );

endinterface

// File: rtl/hazard_forward_unit_match.sv
// Producer/consumer comparator: a scoreboard entry supplies a source operand
// only if it writes the register file, targets that register, the register
// is not $0 and the consuming instruction actually reads the operand.
module hazard_match
    import hazard_forward_unit_pkg::*;
(
    input  logic                  regwrite,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  uses,
    output logic                  hit
);

    assign hit = regwrite && (dest == src) && (src != ZERO_REG) && uses;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forwarding controller. Keeps an EX/MEM
// scoreboard of in-flight producers, raises load-use stalls and branch
// flushes, and registers the cascaded-mux selects for the instruction
// entering EX. Producers leaving MEM are retired: the write-first register
// file already covers a WB-stage producer against an ID read.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    hazard_forward_unit_if.slave  bus
);

    sb_entry_t ex_r;
    sb_entry_t mem_r;

    logic fwd_a_wb_r;
    logic fwd_a_mem_r;
    logic fwd_b_wb_r;
    logic fwd_b_mem_r;

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic hit_ex_rs_s;
    logic hit_ex_rt_s;
    logic hit_mem_rs_s;
    logic hit_mem_rt_s;
    logic luse_s;
    logic flush_s;
    logic pc_hold_s;
    logic ifid_hold_s;
    logic ifid_flush_s;
    logic idex_bubble_s;

    hazard_match u_match_ex_rs (
        .regwrite (ex_r.regwrite), .dest (ex_r.dest),
        .src (bus.id_rs), .uses (bus.id_uses_rs), .hit (hit_ex_rs_s)
    );
    hazard_match u_match_ex_rt (
        .regwrite (ex_r.regwrite), .dest (ex_r.dest),
        .src (bus.id_rt), .uses (bus.id_uses_rt), .hit (hit_ex_rt_s)
    );
    hazard_match u_match_mem_rs (
        .regwrite (mem_r.regwrite), .dest (mem_r.dest),
        .src (bus.id_rs), .uses (bus.id_uses_rs), .hit (hit_mem_rs_s)
    );
    hazard_match u_match_mem_rt (
        .regwrite (mem_r.regwrite), .dest (mem_r.dest),
        .src (bus.id_rt), .uses (bus.id_uses_rt), .hit (hit_mem_rt_s)
    );

    // A load one stage ahead cannot forward yet; a single bubble always suffices.
    assign luse_s  = (hit_ex_rs_s || hit_ex_rt_s) && ex_r.memread;
    assign flush_s = bus.ex_branch_taken;

    // Pipeline control: freeze dominates, then wrong-path flush, then load-use stall.
    always_comb begin
        pc_hold_s     = 1'b0;
        ifid_hold_s   = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        if (bus.pipe_freeze) begin
            pc_hold_s   = 1'b1;
            ifid_hold_s = 1'b1;
        end else if (flush_s) begin
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
        end else if (luse_s) begin
            pc_hold_s     = 1'b1;
            ifid_hold_s   = 1'b1;
            idex_bubble_s = 1'b1;
        end else begin
            idex_bubble_s = 1'b0;
        end
    end

    // Scoreboard shift, forward-select capture and event counting on each unfrozen edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_r        <= SB_INVALID;
            mem_r       <= SB_INVALID;
            fwd_a_wb_r  <= 1'b0;
            fwd_a_mem_r <= 1'b0;
            fwd_b_wb_r  <= 1'b0;
            fwd_b_mem_r <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (!bus.pipe_freeze) begin
            mem_r <= ex_r;
            if (idex_bubble_s) begin
                ex_r        <= SB_INVALID;
                fwd_a_wb_r  <= 1'b0;
                fwd_a_mem_r <= 1'b0;
                fwd_b_wb_r  <= 1'b0;
                fwd_b_mem_r <= 1'b0;
            end else begin
                ex_r        <= '{dest: bus.id_dest, regwrite: bus.id_regwrite, memread: bus.id_memread};
                fwd_a_wb_r  <= hit_mem_rs_s;
                fwd_a_mem_r <= hit_ex_rs_s && !ex_r.memread;
                fwd_b_wb_r  <= hit_mem_rt_s;
                fwd_b_mem_r <= hit_ex_rt_s && !ex_r.memread;
            end
            stall_cnt_r <= sat_inc(stall_cnt_r, luse_s && !flush_s);
            flush_cnt_r <= sat_inc(flush_cnt_r, flush_s);
        end
    end

    assign bus.pc_hold       = pc_hold_s;
    assign bus.ifid_hold     = ifid_hold_s;
    assign bus.ifid_flush    = ifid_flush_s;
    assign bus.idex_bubble   = idex_bubble_s;
    assign bus.fwd_a_wb_sel  = fwd_a_wb_r;
    assign bus.fwd_a_mem_sel = fwd_a_mem_r;
    assign bus.fwd_b_wb_sel  = fwd_b_wb_r;
    assign bus.fwd_b_mem_sel = fwd_b_mem_r;
    assign bus.stall_count   = stall_cnt_r;
    assign bus.flush_count   = flush_cnt_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: short instruction sequences with
// hand-derived stall/flush controls, forward selects and counter values.
module tb_hazard_forward_unit;
    import hazard_forward_unit_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hazard_forward_unit_if bus ();

    hazard_forward_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {a_wb, a_mem, b_wb, b_mem} and {pc_hold, ifid_hold, ifid_flush, idex_bubble}
    wire [3:0] sels = {bus.fwd_a_wb_sel, bus.fwd_a_mem_sel, bus.fwd_b_wb_sel, bus.fwd_b_mem_sel};
    wire [3:0] ctl  = {bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble};

    // free-running pipeline clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                          input logic [4:0] dest, input logic rw, input logic mr);
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_uses_rs  = urs;
        bus.id_uses_rt  = urt;
        bus.id_dest     = dest;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        #1;
    endtask

    task automatic set_nop;
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset;
        reset               = 1'b1;
        bus.pipe_freeze     = 1'b0;
        bus.ex_branch_taken = 1'b0;
        set_nop();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        bus.pipe_freeze     = 1'b0;
        bus.ex_branch_taken = 1'b0;
        set_nop();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (sels !== 4'b0000) begin failures++; $display("FAIL reset_sels got=%b exp=0000", sels); end
        checks++;
        if (ctl !== 4'b0000) begin failures++; $display("FAIL reset_ctl got=%b exp=0000", ctl); end
        checks++;
        if (bus.stall_count !== 16'd0 || bus.flush_count !== 16'd0) begin
            failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus.stall_count, bus.flush_count);
        end
        reset = 1'b0;
    endtask

    // add $3,$1,$2 ; sub $4,$3,$5
    task automatic test_ex_forward;
        do_reset();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        set_id(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        checks++;
        if (ctl !== 4'b0000) begin failures++; $display("FAIL exfwd_nostall got=%b exp=0000", ctl); end
        step();
        checks++;
        if (sels !== 4'b0100) begin failures++; $display("FAIL exfwd_sels got=%b exp=0100", sels); end
    endtask

    // add $3 ; nop ; or $6,$7,$3
    task automatic test_mem_forward;
        do_reset();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        set_nop();
        step();
        set_id(5'd7, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        step();
        checks++;
        if (sels !== 4'b0010) begin failures++; $display("FAIL memfwd_sels got=%b exp=0010", sels); end
    endtask

    // add $3 ; add $3 ; sub $4,$3,$3 -> newest producer wins in the 2nd mux
    task automatic test_double_producer;
        logic [31:0] opa;
        do_reset();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        step();
        checks++;
        if (sels !== 4'b1111) begin failures++; $display("FAIL dbl_sels got=%b exp=1111", sels); end
        opa = bus.fwd_a_wb_sel ? 32'h0000_AAAA : 32'h0000_1111;
        opa = bus.fwd_a_mem_sel ? 32'h0000_BBBB : opa;
        checks++;
        if (opa !== 32'h0000_BBBB) begin failures++; $display("FAIL dbl_operand got=%h exp=0000bbbb", opa); end
    endtask

    // lw $8,0($9) ; add $10,$8,$1
    task automatic test_load_use;
        do_reset();
        set_id(5'd9, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        set_id(5'd8, 5'd1, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        checks++;
        if (ctl !== 4'b1101) begin failures++; $display("FAIL luse_ctl got=%b exp=1101", ctl); end
        step();
        checks++;
        if (ctl !== 4'b0000) begin failures++; $display("FAIL luse_release got=%b exp=0000", ctl); end
        checks++;
        if (sels !== 4'b0000) begin failures++; $display("FAIL luse_bubble_sels got=%b exp=0000", sels); end
        checks++;
        if (bus.stall_count !== 16'd1) begin failures++; $display("FAIL luse_stall_cnt got=%0d exp=1", bus.stall_count); end
        step();
        checks++;
        if (sels !== 4'b1000) begin failures++; $display("FAIL luse_wb_sels got=%b exp=1000", sels); end
        checks++;
        if (bus.stall_count !== 16'd1) begin failures++; $display("FAIL luse_stall_cnt2 got=%0d exp=1", bus.stall_count); end
    endtask

    // writes to $0 never forward or stall; flush beats a concurrent load-use
    task automatic test_zero_and_flush;
        do_reset();
        set_id(5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        step();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        step();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        checks++;
        if (ctl !== 4'b0000) begin failures++; $display("FAIL zero_nostall got=%b exp=0000", ctl); end
        step();
        checks++;
        if (sels !== 4'b0000) begin failures++; $display("FAIL zero_sels got=%b exp=0000", sels); end

        do_reset();
        set_id(5'd9, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        set_id(5'd8, 5'd1, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        bus.ex_branch_taken = 1'b1;
        #1;
        checks++;
        if (ctl !== 4'b0011) begin failures++; $display("FAIL flush_ctl got=%b exp=0011", ctl); end
        step();
        bus.ex_branch_taken = 1'b0;
        #1;
        checks++;
        if (bus.flush_count !== 16'd1 || bus.stall_count !== 16'd0) begin
            failures++; $display("FAIL flush_counts got=%0d/%0d exp=1/0", bus.flush_count, bus.stall_count);
        end
        checks++;
        if (sels !== 4'b0000) begin failures++; $display("FAIL flush_sels got=%b exp=0000", sels); end
    endtask

    // freeze holds selects and counters; reset during a stall clears everything
    task automatic test_freeze_and_reset;
        do_reset();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        set_id(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        bus.pipe_freeze = 1'b1;
        #1;
        checks++;
        if (ctl !== 4'b1100) begin failures++; $display("FAIL freeze_ctl got=%b exp=1100", ctl); end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (sels !== 4'b0000) begin failures++; $display("FAIL freeze_sels_hold0 got=%b exp=0000", sels); end
        bus.pipe_freeze = 1'b0;
        step();
        checks++;
        if (sels !== 4'b0100) begin failures++; $display("FAIL freeze_release_sels got=%b exp=0100", sels); end
        bus.pipe_freeze = 1'b1;
        set_nop();
        step();
        step();
        checks++;
        if (sels !== 4'b0100) begin failures++; $display("FAIL freeze_sels_hold1 got=%b exp=0100", sels); end

        bus.pipe_freeze = 1'b0;
        set_id(5'd9, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        set_id(5'd8, 5'd1, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        bus.pipe_freeze = 1'b1;
        step();
        step();
        checks++;
        if (bus.stall_count !== 16'd0) begin failures++; $display("FAIL freeze_stall_cnt got=%0d exp=0", bus.stall_count); end
        bus.pipe_freeze = 1'b0;
        step();
        checks++;
        if (bus.stall_count !== 16'd1) begin failures++; $display("FAIL unfreeze_stall_cnt got=%0d exp=1", bus.stall_count); end

        do_reset();
        set_id(5'd9, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        set_id(5'd8, 5'd8, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        checks++;
        if (ctl !== 4'b1101) begin failures++; $display("FAIL rst_mid_pre got=%b exp=1101", ctl); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b0000 || sels !== 4'b0000) begin
            failures++; $display("FAIL rst_mid_outputs got=%b/%b exp=0000/0000", ctl, sels);
        end
        checks++;
        if (bus.stall_count !== 16'd0 || bus.flush_count !== 16'd0) begin
            failures++; $display("FAIL rst_mid_counts got=%0d/%0d exp=0/0", bus.stall_count, bus.flush_count);
        end
    endtask

    // add $3 ; add $5,$3,$3 ; sub $6,$5,$3 then lw $8 ; nop ; add $10,$8,$1
    task automatic test_back_to_back;
        do_reset();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        step();
        set_id(5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        step();
        checks++;
        if (sels !== 4'b0110) begin failures++; $display("FAIL b2b_chain_sels got=%b exp=0110", sels); end
        set_id(5'd9, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        set_nop();
        step();
        set_id(5'd8, 5'd6, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
        checks++;
        if (ctl !== 4'b0000) begin failures++; $display("FAIL b2b_load_nostall got=%b exp=0000", ctl); end
        step();
        checks++;
        if (sels !== 4'b1000) begin failures++; $display("FAIL b2b_load_sels got=%b exp=1000", sels); end
    endtask

    // test sequence
    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_double_producer();
        test_load_use();
        test_zero_and_flush();
        test_freeze_and_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
